ws2812b_stream_out: RTL and testbench

//  Parametrised WS2812B/SK6812 serial driver: accepts pixels over a valid/ready stream and serialises fixed-length frames of
//  NUM_LEDS pixels, BITS per pixel, with programmable bit timing and latch (reset) gap. One-entry pixel buffer for back-to-back

---
 rtl/ws2812b_stream_out.sv | 143 ++++++++++++++
 tb/tb_ws2812b_stream_out.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_stream_out.sv
// ws2812b_stream_out: buffers one pixel from a valid/ready stream and serialises NUM_LEDS-pixel
// frames onto a WS2812B/SK6812 data pin, each frame followed by a latch gap.
module ws2812b_stream_out #(
    parameter int BITS       = 24,
    parameter int NUM_LEDS   = 64,
    parameter int CYCLES_T0H = 3,
    parameter int CYCLES_T1H = 5,
    parameter int CYCLES_BIT = 8,
    parameter int CYCLES_RET = 450,
    parameter bit MSB_FIRST  = 1'b1,
    localparam int IDX_W     = $clog2(NUM_LEDS + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             pix_valid,
    input  logic [BITS-1:0]  pix_data,
    output logic             pix_ready,
    output logic             ws2812b_data,
    output logic             busy,
    output logic [IDX_W-1:0] led_index,
    output logic             frame_done,
    output logic             underrun
);
    localparam int CNT_MAX = CYCLES_RET > CYCLES_BIT ? CYCLES_RET : CYCLES_BIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(BITS + 1);
    // Counters hold "cycles left minus one", so a phase ends when the counter reads zero.
    localparam logic [CNT_W-1:0] H0 = CNT_W'(CYCLES_T0H - 1);
    localparam logic [CNT_W-1:0] H1 = CNT_W'(CYCLES_T1H - 1);
    localparam logic [CNT_W-1:0] L0 = CNT_W'(CYCLES_BIT - CYCLES_T0H - 1);
    localparam logic [CNT_W-1:0] L1 = CNT_W'(CYCLES_BIT - CYCLES_T1H - 1);
    localparam logic [CNT_W-1:0] RL = CNT_W'(CYCLES_RET - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, RET} state_t;

    state_t           state_q, state_d;
    logic [BITS-1:0]  buf_q, buf_d, shift_q, shift_d, next_shift;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             buf_full_q, buf_full_d, data_q, data_d, ready_q, ready_d, busy_q, busy_d;
    logic             frame_done_q, frame_done_d, underrun_q, underrun_d, load;

    function automatic logic head(input logic [BITS-1:0] w);
        return MSB_FIRST ? w[BITS-1] : w[0];
    endfunction

    assign next_shift = MSB_FIRST ? shift_q << 1 : shift_q >> 1;

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q;
        shift_d      = shift_q;
        bit_d        = bit_q;
        cnt_d        = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        idx_d        = idx_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        load         = 1'b0;
        if (pix_valid && !buf_full_q) begin
            buf_d      = pix_data;
            buf_full_d = 1'b1;
        end
        case (state_q)
            IDLE: load = enable && buf_full_q;
            HIGH: if (cnt_q == '0) begin
                state_d = LOW;
                data_d  = 1'b0;
                cnt_d   = head(shift_q) ? L1 : L0;
            end
            LOW: if (cnt_q == '0) begin
                if (bit_q != '0) begin
                    state_d = HIGH;
                    data_d  = 1'b1;
                    shift_d = next_shift;
                    bit_d   = bit_q - 1'b1;
                    cnt_d   = head(next_shift) ? H1 : H0;
                end else if (idx_q != LAST_IDX && buf_full_q) begin
                    load  = 1'b1;
                    idx_d = idx_q + 1'b1;
                end else begin
                    state_d      = RET;
                    cnt_d        = RL;
                    idx_d        = '0;
                    frame_done_d = idx_q == LAST_IDX;
                    underrun_d   = idx_q != LAST_IDX;
                end
            end
            default: if (cnt_q == '0) state_d = IDLE;
        endcase
        if (load) begin
            state_d    = HIGH;
            data_d     = 1'b1;
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            bit_d      = BIT_W'(BITS - 1);
            cnt_d      = head(buf_q) ? H1 : H0;
        end
        ready_d = !buf_full_d;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            shift_q      <= '0;
            bit_q        <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            data_q       <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            shift_q      <= shift_d;
            bit_q        <= bit_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign pix_ready    = ready_q;
    assign ws2812b_data = data_q;
    assign busy         = busy_q;
    assign led_index    = idx_q;
    assign frame_done   = frame_done_q;
    assign underrun     = underrun_q;
endmodule

// File: tb/tb_ws2812b_stream_out.sv
// tb_ws2812b_stream_out: drives MSB-first and LSB-first drivers with the same pixel stream and
// decodes the selected serial pin back into pulse widths, pixel indices and end-of-frame events.
module tb_ws2812b_stream_out;
    localparam int CB = 6;
    localparam int CR = 10;
    localparam int W0 = 2;
    localparam int W1 = 4;

    typedef struct {int w; int idx; bit first;} item_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data = '0;
    logic       sel = 1'b0;
    logic       rdy_a, ws_a, busy_a, fd_a, ur_a, rdy_b, ws_b, busy_b, fd_b, ur_b;
    logic [1:0] idx_a, idx_b;
    logic       m_ws, m_busy, m_fd, m_ur, m_rdy;
    logic [1:0] m_idx;

    int    checks = 0, failures = 0;
    item_t exp_q[$];
    int    ev_q[$];
    item_t it;
    int    mcyc = 0, last_rise = 0, cur_w = 0, ev_cyc = 0;
    bit    prev_ws = 0, prev_busy = 0, have_rise = 0;

    always #5 clk = ~clk;

    ws2812b_stream_out #(.BITS(8), .NUM_LEDS(2), .CYCLES_T0H(2), .CYCLES_T1H(4), .CYCLES_BIT(6),
        .CYCLES_RET(10), .MSB_FIRST(1)) u_a (
        .clk(clk), .resetn(resetn), .enable(enable), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(rdy_a), .ws2812b_data(ws_a), .busy(busy_a), .led_index(idx_a),
        .frame_done(fd_a), .underrun(ur_a));

    ws2812b_stream_out #(.BITS(8), .NUM_LEDS(2), .CYCLES_T0H(2), .CYCLES_T1H(4), .CYCLES_BIT(6),
        .CYCLES_RET(10), .MSB_FIRST(0)) u_b (
        .clk(clk), .resetn(resetn), .enable(enable), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(rdy_b), .ws2812b_data(ws_b), .busy(busy_b), .led_index(idx_b),
        .frame_done(fd_b), .underrun(ur_b));

    assign m_ws   = sel ? ws_b : ws_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_fd   = sel ? fd_b : fd_a;
    assign m_ur   = sel ? ur_b : ur_a;
    assign m_rdy  = sel ? rdy_b : rdy_a;
    assign m_idx  = sel ? idx_b : idx_a;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    // Reference: each pixel becomes eight pulse widths in transmit order.
    task automatic add_exp(input logic [7:0] p, input int idx, input bit msb);
        for (int k = 0; k < 8; k++) begin
            item_t e;
            logic b;
            b = msb ? p[7-k] : p[k];
            e.w = b ? W1 : W0;
            e.idx = idx;
            e.first = (idx == 0) && (k == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic push(input logic [7:0] p);
        int t = 0;
        pix_valid = 1'b1;
        pix_data = p;
        while (!m_rdy && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("push_accepted", int'(t < 300), 1);
        @(posedge clk); #1;
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!m_busy && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("frame_started", int'(m_busy), 1);
        while (m_busy && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        chk("frame_finished", int'(m_busy), 0);
    endtask

    task automatic run_frame(input int n, input bit s, input logic [7:0] p0, input logic [7:0] p1);
        sel = s;
        for (int i = 0; i < n; i++) begin
            add_exp(i == 0 ? p0 : p1, i, !s);
            push(i == 0 ? p0 : p1);
        end
        ev_q.push_back(n == 2 ? 0 : 1);
        wait_idle();
        chk("idle_ready", int'(m_rdy), 1);
        chk("idle_index", int'(m_idx), 0);
    endtask

    always @(negedge clk) begin
        mcyc++;
        if (!resetn) begin
            prev_ws = 0;
            prev_busy = 0;
            have_rise = 0;
        end else begin
            if (m_ws && !prev_ws) begin
                chk("bit_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    it = exp_q.pop_front();
                    chk("led_index", int'(m_idx), it.idx);
                    chk("busy_in_bit", int'(m_busy), 1);
                    if (!it.first && have_rise) chk("bit_period", mcyc - last_rise, CB);
                    cur_w = it.w;
                end
                last_rise = mcyc;
                have_rise = 1;
            end
            if (!m_ws && prev_ws) chk("high_width", mcyc - last_rise, cur_w);
            if (m_fd || m_ur) begin
                chk("pulse_exclusive", int'(m_fd && m_ur), 0);
                chk("pulse_expected", int'(ev_q.size() > 0), 1);
                if (ev_q.size() > 0) chk("end_kind_underrun", int'(m_ur), ev_q.pop_front());
                chk("last_bit_period", mcyc - last_rise, CB);
                chk("end_index", int'(m_idx), 0);
                ev_cyc = mcyc;
            end
            if (!m_busy && prev_busy) chk("ret_length", mcyc - ev_cyc, CR);
            prev_ws = m_ws;
            prev_busy = m_busy;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        chk("rst_ws", int'(ws_a), 0);
        chk("rst_ready", int'(rdy_a), 1);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_index", int'(idx_a), 0);
        chk("rst_pulses", int'(fd_a | ur_a | fd_b | ur_b), 0);
        enable = 1'b1;
        run_frame(2, 1'b0, 8'hA5, 8'h0F);
        run_frame(1, 1'b0, 8'hFF, 8'h00);
        run_frame(2, 1'b1, 8'h01, 8'h80);
        // Held-off start: a full buffer waits in IDLE until enable rises.
        sel = 1'b0;
        enable = 1'b0;
        add_exp(8'h3C, 0, 1'b1);
        push(8'h3C);
        repeat (4) @(posedge clk);
        #1;
        chk("hold_ready", int'(rdy_a), 0);
        chk("hold_busy", int'(busy_a), 0);
        chk("hold_ws", int'(ws_a), 0);
        enable = 1'b1;
        @(posedge clk); #1;
        chk("start_ws", int'(ws_a), 1);
        chk("start_busy", int'(busy_a), 1);
        ev_q.push_back(1);
        wait_idle();
        repeat (8) begin
            int n;
            logic s;
            logic [7:0] p0, p1;
            n = $urandom_range(1, 2);
            s = 1'($urandom_range(0, 1));
            p0 = 8'($urandom);
            p1 = 8'($urandom);
            run_frame(n, s, p0, p1);
        end
        chk("model_drained", exp_q.size() + ev_q.size(), 0);
        // Abort mid-pixel 1 with the next frame's pixel already buffered.
        sel = 1'b0;
        add_exp(8'h96, 0, 1'b1);
        push(8'h96);
        add_exp(8'h69, 1, 1'b1);
        push(8'h69);
        begin
            int t = 0;
            while (idx_a != 2'd1 && t < 200) begin
                @(posedge clk); #1;
                t++;
            end
            chk("reached_pixel1", int'(idx_a), 1);
        end
        push(8'hE7);
        repeat (3) @(posedge clk);
        #1;
        chk("buffer_filled", int'(rdy_a), 0);
        exp_q.delete();
        ev_q.delete();
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        chk("abort_ws", int'(ws_a), 0);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_ready", int'(rdy_a), 1);
        chk("abort_index", int'(idx_a), 0);
        repeat (120) @(posedge clk);
        #1;
        chk("abort_stays_idle", int'(busy_a | ws_a), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
